// File: rtl/imm_field_packer_if.sv
// imm_field_packer_if: input/output handshake bundle for the immediate packer
interface imm_field_packer_if #(parameter int CNT_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [63:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] err_count;
  modport master (output in_valid, in_instr, in_imm, out_ready,
                  input in_ready, out_valid, out_instr, out_err, err_count);
  modport slave (input in_valid, in_instr, in_imm, out_ready,
                 output in_ready, out_valid, out_instr, out_err, err_count);
endinterface

// File: rtl/imm_field_packer.sv
// imm_field_packer: two-stage pipeline inserting a signed immediate into an instruction field
module imm_field_packer #(
  parameter int CNT_W = 8
) (
  input logic clock,
  input logic reset_n,
  imm_field_packer_if.slave bus
);
  logic             s1_valid, s1_fit, s1_bad;
  logic [31:0]      s1_instr;
  logic [25:0]      s1_imm;
  logic             s2_valid, s2_err;
  logic [31:0]      s2_instr;
  logic [CNT_W-1:0] cnt;
  logic             adv;
  logic [5:0]       sh;
  logic [63:0]      hi;
  logic             fit;
  logic [4:0]       lo;
  logic [31:0]      mask, merged;
  assign adv = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_instr = s2_instr;
  assign bus.out_err = s2_err;
  assign bus.err_count = cnt;
  // range check on the incoming immediate and field merge of the stage-1 word
  always_comb begin
    sh = bus.in_instr[31:30] == 2'b11 ? 6'd8 : bus.in_instr[31:30] == 2'b10 ? 6'd18 : 6'd25;
    hi = $signed(bus.in_imm) >>> sh;
    fit = &hi | ~|hi;
    lo = s1_instr[31:30] == 2'b11 ? 5'd12 : s1_instr[31:30] == 2'b10 ? 5'd5 : 5'd0;
    mask = s1_instr[31:30] == 2'b11 ? 32'h001F_F000 :
           s1_instr[31:30] == 2'b10 ? 32'h00FF_FFE0 : 32'h03FF_FFFF;
    merged = s1_bad ? s1_instr : (s1_instr & ~mask) | (({6'd0, s1_imm} << lo) & mask);
  end
  // stage 1: capture word, low immediate bits and check results on accept
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_imm <= '0;
      s1_fit <= 1'b0;
      s1_bad <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_instr <= bus.in_instr;
        s1_imm <= bus.in_imm[25:0];
        s1_fit <= fit;
        s1_bad <= bus.in_instr[31:30] == 2'b01;
      end
    end
  end
  // stage 2: registered output word, held while the consumer stalls
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_err <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_instr <= merged;
        s2_err <= s1_bad || !s1_fit;
      end
    end
  end
  // saturating count of errored words handed off
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (s2_valid && bus.out_ready && s2_err && ~&cnt) cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_imm_field_packer.sv
// tb_imm_field_packer: randomized and directed checks against a behavioural packing model
module tb_imm_field_packer;
  localparam int CNT_W = 8;
  localparam int MAXC = (1 << CNT_W) - 1;
  localparam int NW = 10000;
  logic clock = 0;
  logic reset_n = 0;
  int passed = 0;
  int total = 0;
  int errs_m = 0;
  always #5 clock = ~clock;
  imm_field_packer_if #(.CNT_W(CNT_W)) bus ();
  imm_field_packer #(.CNT_W(CNT_W)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  function automatic int fw(input logic [1:0] op);
    return op == 2'b11 ? 9 : op == 2'b10 ? 19 : 26;
  endfunction
  function automatic int flo(input logic [1:0] op);
    return op == 2'b11 ? 12 : op == 2'b10 ? 5 : 0;
  endfunction
  function automatic void model(input logic [31:0] instr, input logic [63:0] imm,
                                output logic [31:0] r, output logic e);
    int w, lo;
    longint lim;
    w = fw(instr[31:30]);
    lo = flo(instr[31:30]);
    r = instr;
    e = 1'b1;
    if (instr[31:30] == 2'b01) return;
    for (int b = 0; b < w; b++) r[lo+b] = imm[b];
    lim = longint'(1) << (w - 1);
    e = !($signed(imm) >= -lim && $signed(imm) < lim);
  endfunction
  function automatic logic [63:0] unpack(input logic [31:0] x);
    logic [63:0] v;
    int w, lo;
    w = fw(x[31:30]);
    lo = flo(x[31:30]);
    for (int b = 0; b < 64; b++) v[b] = x[lo + (b < w ? b : w - 1)];
    return v;
  endfunction
  function automatic logic [63:0] rimm();
    logic signed [63:0] s;
    s = {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) return s;
    return s >>> $urandom_range(30, 63);
  endfunction
  task automatic test_reset;
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus.in_instr = 0;
    bus.in_imm = 0;
    reset_n = 0;
    repeat (3) @(negedge clock);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_err !== 1'b0) $display("FAIL reset_out_err got %0b want 0", bus.out_err); else passed++;
    total++; if (bus.out_instr !== 32'h0) $display("FAIL reset_out_instr got %h want 0", bus.out_instr); else passed++;
    total++; if (bus.err_count !== '0) $display("FAIL reset_err_count got %0d want 0", bus.err_count); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); else passed++;
    reset_n = 1;
    errs_m = 0;
  endtask
  task automatic test_directed;
    logic [31:0] ti [8];
    logic [63:0] tm [8];
    logic [31:0] xi;
    logic xe;
    int lat;
    ti = '{32'hF800_0000, 32'hF800_0000, 32'hF800_0000, 32'hF800_0000,
           32'hB400_0000, 32'h1400_0000, 32'h1400_0000, 32'h4000_1234};
    tm = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd255, 64'd256, 64'hFFFF_FFFF_FFFF_FF00,
           64'd4, 64'h1FF_FFFF, 64'h200_0000, 64'h0123_4567_89AB_CDEF};
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      bus.in_valid = 1;
      bus.in_instr = ti[i];
      bus.in_imm = tm[i];
      bus.out_ready = 1;
      model(ti[i], tm[i], xi, xe);
      #1;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL dir%0d_in_ready got %0b want 1", i, bus.in_ready); else passed++;
      @(negedge clock);
      bus.in_valid = 0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 8) begin
        @(negedge clock);
        lat++;
      end
      total++; if (lat !== 2) $display("FAIL dir%0d_latency got %0d want 2", i, lat); else passed++;
      total++; if (bus.out_instr !== xi) $display("FAIL dir%0d_instr got %h want %h", i, bus.out_instr, xi); else passed++;
      total++; if (bus.out_err !== xe) $display("FAIL dir%0d_err got %0b want %0b", i, bus.out_err, xe); else passed++;
      @(negedge clock);
      if (xe && errs_m < MAXC) errs_m++;
      total++; if (bus.err_count !== CNT_W'(errs_m)) $display("FAIL dir%0d_err_count got %0d want %0d", i, bus.err_count, errs_m); else passed++;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL dir%0d_no_dup got %0b want 0", i, bus.out_valid); else passed++;
    end
  endtask
  task automatic test_backpressure;
    logic [31:0] wi [4];
    logic [63:0] wm [4];
    logic [31:0] ei [4];
    logic ee [4];
    int k = 0;
    int got = 0;
    for (int i = 0; i < 4; i++) begin
      wi[i] = $urandom;
      if (wi[i][31:30] == 2'b01) wi[i][31:30] = 2'b00;
      wm[i] = rimm();
      model(wi[i], wm[i], ei[i], ee[i]);
    end
    bus.out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (c >= 2) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== ei[0] || bus.out_err !== ee[0])
          $display("FAIL bp_stall_c%0d got v=%0b %h e=%0b want v=1 %h e=%0b", c, bus.out_valid, bus.out_instr, bus.out_err, ei[0], ee[0]);
        else passed++;
      end
      bus.in_valid = k < 4;
      bus.in_instr = wi[k < 4 ? k : 0];
      bus.in_imm = wm[k < 4 ? k : 0];
      #1;
      if (bus.in_valid && bus.in_ready) k++;
    end
    total++; if (k !== 2) $display("FAIL bp_accepted got %0d want 2", k); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready got %0b want 0", bus.in_ready); else passed++;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clock);
      bus.out_ready = 1;
      bus.in_valid = k < 4;
      bus.in_instr = wi[k < 4 ? k : 0];
      bus.in_imm = wm[k < 4 ? k : 0];
      #1;
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (bus.out_instr !== ei[got] || bus.out_err !== ee[got])
          $display("FAIL bp_word%0d got %h e=%0b want %h e=%0b", got, bus.out_instr, bus.out_err, ei[got], ee[got]);
        else passed++;
        if (ee[got] && errs_m < MAXC) errs_m++;
        got++;
      end
      if (bus.in_valid && bus.in_ready) k++;
    end
    bus.in_valid = 0;
    total++; if (got !== 4) $display("FAIL bp_drained got %0d want 4", got); else passed++;
    @(negedge clock);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_no_dup got %0b want 0", bus.out_valid); else passed++;
    total++; if (bus.err_count !== CNT_W'(errs_m)) $display("FAIL bp_err_count got %0d want %0d", bus.err_count, errs_m); else passed++;
  endtask
  task automatic test_random;
    logic [31:0] qi [$];
    logic qe [$];
    logic [63:0] qm [$];
    logic [31:0] ci, xi, pi;
    logic [63:0] cm, xm;
    logic xe, pe;
    logic pstall = 0;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int bad = 0;
    ci = $urandom;
    cm = rimm();
    while (got < NW && cyc < 60000) begin
      @(negedge clock);
      cyc++;
      total++; if (bus.err_count !== CNT_W'(errs_m)) begin bad++; if (bad < 10) $display("FAIL rnd_err_count got %0d want %0d", bus.err_count, errs_m); end else passed++;
      if (pstall) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== pi || bus.out_err !== pe) begin
          bad++;
          if (bad < 10) $display("FAIL rnd_hold got v=%0b %h e=%0b want v=1 %h e=%0b", bus.out_valid, bus.out_instr, bus.out_err, pi, pe);
        end else passed++;
      end
      bus.in_valid = sent < NW && $urandom_range(0, 3) != 0;
      bus.in_instr = ci;
      bus.in_imm = cm;
      bus.out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (qi.size() == 0) begin
          bad++;
          $display("FAIL rnd_spurious got %h want none", bus.out_instr);
        end else begin
          xi = qi.pop_front();
          xe = qe.pop_front();
          xm = qm.pop_front();
          if (bus.out_instr !== xi || bus.out_err !== xe) begin
            bad++;
            if (bad < 10) $display("FAIL rnd_word%0d got %h e=%0b want %h e=%0b", got, bus.out_instr, bus.out_err, xi, xe);
          end else passed++;
          if (!xe) begin
            total++;
            if (unpack(bus.out_instr) !== xm) begin
              bad++;
              if (bad < 10) $display("FAIL rnd_roundtrip%0d got %h want %h", got, unpack(bus.out_instr), xm);
            end else passed++;
          end
          if (xe && errs_m < MAXC) errs_m++;
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        model(ci, cm, xi, xe);
        qi.push_back(xi);
        qe.push_back(xe);
        qm.push_back(cm);
        sent++;
        ci = $urandom;
        cm = rimm();
      end
      pstall = bus.out_valid && !bus.out_ready;
      pi = bus.out_instr;
      pe = bus.out_err;
    end
    bus.in_valid = 0;
    total++; if (got !== NW) $display("FAIL rnd_count got %0d want %0d", got, NW); else passed++;
  endtask
  task automatic test_saturation;
    int sent = 0;
    int got = 0;
    for (int c = 0; c < 1000 && got < 260; c++) begin
      @(negedge clock);
      bus.in_valid = sent < 260;
      bus.in_instr = {2'b01, 30'($urandom)};
      bus.in_imm = {$urandom, $urandom};
      bus.out_ready = 1;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        got++;
        if (bus.out_err && errs_m < MAXC) errs_m++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid = 0;
    @(negedge clock);
    total++; if (got !== 260) $display("FAIL sat_handoffs got %0d want 260", got); else passed++;
    total++; if (bus.err_count !== CNT_W'(MAXC)) $display("FAIL sat_err_count got %0d want %0d", bus.err_count, MAXC); else passed++;
  endtask
  task automatic test_reset_mid;
    logic [31:0] xi;
    logic xe;
    int lat;
    bus.out_ready = 0;
    bus.in_valid = 1;
    bus.in_instr = 32'hF800_0000;
    bus.in_imm = 64'd5;
    repeat (3) @(negedge clock);
    total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) $display("FAIL rst_mid_full got v=%0b r=%0b want v=1 r=0", bus.out_valid, bus.in_ready); else passed++;
    #2 reset_n = 0;
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got %0b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_instr !== 32'h0 || bus.out_err !== 1'b0) $display("FAIL rst_mid_out got %h e=%0b want 0", bus.out_instr, bus.out_err); else passed++;
    total++; if (bus.err_count !== '0) $display("FAIL rst_mid_err_count got %0d want 0", bus.err_count); else passed++;
    errs_m = 0;
    @(negedge clock);
    reset_n = 1;
    bus.in_valid = 1;
    bus.in_instr = 32'hB400_0000;
    bus.in_imm = 64'd4;
    bus.out_ready = 1;
    model(32'hB400_0000, 64'd4, xi, xe);
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_rel_in_ready got %0b want 1", bus.in_ready); else passed++;
    @(negedge clock);
    bus.in_valid = 0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 8) begin
      @(negedge clock);
      lat++;
    end
    total++; if (lat !== 2) $display("FAIL rst_rel_latency got %0d want 2", lat); else passed++;
    total++; if (bus.out_instr !== xi || bus.out_err !== xe) $display("FAIL rst_rel_word got %h e=%0b want %h e=%0b", bus.out_instr, bus.out_err, xi, xe); else passed++;
  endtask
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
